tlb_storage: RTL and testbench
==============================

TLB_STORAGE -- requirements
Module: tlb_storage

Interface
REQ-001 The module SHALL take its parameters from the shared header tlb_params.vh.
REQ-002 The module SHALL implement the following parameters:
- NUM_SETS, default 16, number of sets.
- NUM_WAYS, default 4, ways per set.
- SET_INDEX_BITS, default 4, log2(NUM_SETS).
- LRU_BITS, default 4, width of the per-entry LRU counter.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- rd_set_index, in, SET_INDEX_BITS, set to read.
- rd_valid, out, 1 x NUM_WAYS (unpacked array), valid bit of each way in the read set.
- rd_vpn, out, 20 x NUM_WAYS, VPN of each way.
- rd_ppn, out, 20 x NUM_WAYS, PPN of each way.
- rd_perms, out, 2 x NUM_WAYS, permission bits of each way.
- rd_lru_count, out, LRU_BITS x NUM_WAYS, LRU counter of each way.
- wr_en, in, 1, full-entry write strobe.
- wr_set_index, in, SET_INDEX_BITS, write set.
- wr_way, in, 2, write way.
- wr_valid, in, 1, valid bit to store.
- wr_vpn, in, 20, VPN to store.
- wr_ppn, in, 20, PPN to store.
- wr_perms, in, 2, permissions to store.
- wr_lru_count, in, LRU_BITS, LRU counter to store.
- lru_update_en, in, 1, LRU-only update strobe.
- lru_set_index, in, SET_INDEX_BITS, LRU update set.
- lru_way, in, 2, LRU update way.
- lru_value, in, LRU_BITS, new LRU counter.

Function
REQ-005 Storage SHALL hold NUM_SETS x NUM_WAYS entries of {valid, vpn[19:0], ppn[19:0], perms[1:0], lru_count[LRU_BITS-1:0]}.
REQ-006 Read SHALL be purely combinational: all rd_* outputs present all ways of set rd_set_index with zero-cycle latency, and change within the same delta when rd_set_index or storage changes.
REQ-007 When wr_en=1 at a rising edge, entry [wr_set_index][wr_way] SHALL take all five write fields; the new value is visible on the read outputs immediately after that edge.
REQ-008 When lru_update_en=1 at a rising edge, only the lru_count of entry [lru_set_index][lru_way] SHALL be updated to lru_value; other fields are unchanged.
REQ-009 If wr_en and lru_update_en are both asserted on the same edge and target the same set and way, the write SHALL win: lru_count = wr_lru_count.
REQ-010 If both are asserted and target different entries, both updates SHALL take effect on the same edge.
REQ-011 The module SHALL have no read-during-write forwarding: a combinational read of the entry being written shows the old value until the edge.
REQ-012 Entries not addressed SHALL hold their value; no handshake or stall exists.

Reset
REQ-013 While rst=1 at a rising edge, all valid bits and all lru_count fields SHALL clear to 0.
REQ-014 rst SHALL have priority over wr_en and lru_update_en in the same cycle.
REQ-015 After reset, rd_valid SHALL read 0 for every way of every set.

Configuration
REQ-016 The macro TLB_STORAGE_FULL_RESET_EN SHALL control vpn/ppn/perms reset:
- Defined: reset also clears vpn, ppn and perms of every entry to 0, so every rd_* output is 0 after reset.
- Undefined: these fields are not reset; only valid and lru_count are cleared, saving reset fan-out.

Verification
REQ-017 Reset scenario: assert rst 2 cycles -> rd_valid[0]=0 for all 16 sets.
REQ-018 Single write scenario: write set 5, way 2, VPN ABCDE, PPN 12345, perms 11 -> next read of set 5 gives rd_valid[2]=1 and the same fields.
REQ-019 Fill and overwrite scenario:
- Fill set 3 ways 0-3 with distinct VPN/PPN/perms -> all four read back correctly.
- Overwrite way 1 with AAAAA/BBBBB/11 -> new values read back; ways 0, 2 and 3 unchanged.
REQ-020 LRU update scenario: write set 7 way 0, then lru_update (7, 0, 15) -> rd_lru_count[0]=15; VPN/PPN unchanged.
REQ-021 Same-entry collision scenario: same edge wr (set 8, way 1, lru 5) and lru_update (8, 1, 10) -> rd_lru_count[1]=5.
REQ-022 All-sets scenario: write way 0 of all 16 sets with VPN 10000+i, PPN 20000+i -> each set reads back its own values.

Source files
------------

// File: rtl/tlb_storage.sv
// Set-associative TLB entry storage: combinational read of a whole set, full-entry write port and LRU-only update port.
// Define TLB_STORAGE_FULL_RESET_EN to also clear vpn/ppn/perms on reset (otherwise only valid and lru_count reset).

`ifndef TLB_PARAMS_VH
`define TLB_PARAMS_VH
`define TLB_NUM_SETS       16
`define TLB_NUM_WAYS       4
`define TLB_SET_INDEX_BITS 4
`define TLB_LRU_BITS       4
`endif

module tlb_storage #(
  parameter int NUM_SETS       = `TLB_NUM_SETS,
  parameter int NUM_WAYS       = `TLB_NUM_WAYS,
  parameter int SET_INDEX_BITS = `TLB_SET_INDEX_BITS,
  parameter int LRU_BITS       = `TLB_LRU_BITS
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [SET_INDEX_BITS-1:0] rd_set_index,
  output logic                      rd_valid     [NUM_WAYS],
  output logic [19:0]               rd_vpn       [NUM_WAYS],
  output logic [19:0]               rd_ppn       [NUM_WAYS],
  output logic [1:0]                rd_perms     [NUM_WAYS],
  output logic [LRU_BITS-1:0]       rd_lru_count [NUM_WAYS],

  input  logic                      wr_en,
  input  logic [SET_INDEX_BITS-1:0] wr_set_index,
  input  logic [1:0]                wr_way,
  input  logic                      wr_valid,
  input  logic [19:0]               wr_vpn,
  input  logic [19:0]               wr_ppn,
  input  logic [1:0]                wr_perms,
  input  logic [LRU_BITS-1:0]       wr_lru_count,

  input  logic                      lru_update_en,
  input  logic [SET_INDEX_BITS-1:0] lru_set_index,
  input  logic [1:0]                lru_way,
  input  logic [LRU_BITS-1:0]       lru_value
);

  logic                valid_mem [NUM_SETS][NUM_WAYS];
  logic [LRU_BITS-1:0] lru_mem   [NUM_SETS][NUM_WAYS];
  logic [19:0]         vpn_mem   [NUM_SETS][NUM_WAYS];
  logic [19:0]         ppn_mem   [NUM_SETS][NUM_WAYS];
  logic [1:0]          perms_mem [NUM_SETS][NUM_WAYS];

  // Control fields: the full write is assigned last so it overrides an LRU update to the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_mem[s][w] <= 1'b0;
          lru_mem[s][w]   <= '0;
        end
      end
    end else begin
      if (lru_update_en) begin
        lru_mem[lru_set_index][lru_way] <= lru_value;
      end
      if (wr_en) begin
        valid_mem[wr_set_index][wr_way] <= wr_valid;
        lru_mem[wr_set_index][wr_way]   <= wr_lru_count;
      end
    end
  end

  // Translation payload: only cleared when the full-reset build option is enabled.
`ifdef TLB_STORAGE_FULL_RESET_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          vpn_mem[s][w]   <= '0;
          ppn_mem[s][w]   <= '0;
          perms_mem[s][w] <= '0;
        end
      end
    end else if (wr_en) begin
      vpn_mem[wr_set_index][wr_way]   <= wr_vpn;
      ppn_mem[wr_set_index][wr_way]   <= wr_ppn;
      perms_mem[wr_set_index][wr_way] <= wr_perms;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      vpn_mem[wr_set_index][wr_way]   <= wr_vpn;
      ppn_mem[wr_set_index][wr_way]   <= wr_ppn;
      perms_mem[wr_set_index][wr_way] <= wr_perms;
    end
  end
`endif

  // Whole-set read straight from storage; no forwarding from the write ports.
  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_rd
    assign rd_valid[g]     = valid_mem[rd_set_index][g];
    assign rd_vpn[g]       = vpn_mem[rd_set_index][g];
    assign rd_ppn[g]       = ppn_mem[rd_set_index][g];
    assign rd_perms[g]     = perms_mem[rd_set_index][g];
    assign rd_lru_count[g] = lru_mem[rd_set_index][g];
  end

endmodule

// File: tb/tb_tlb_storage.sv
// Scoreboard bench for tlb_storage: stimulus pushes expected set contents from an array model,
// a monitor pops and compares them on the falling edge.
module tb_tlb_storage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_set_index;
  logic        rd_valid     [4];
  logic [19:0] rd_vpn       [4];
  logic [19:0] rd_ppn       [4];
  logic [1:0]  rd_perms     [4];
  logic [3:0]  rd_lru_count [4];
  logic        wr_en;
  logic [3:0]  wr_set_index;
  logic [1:0]  wr_way;
  logic        wr_valid;
  logic [19:0] wr_vpn;
  logic [19:0] wr_ppn;
  logic [1:0]  wr_perms;
  logic [3:0]  wr_lru_count;
  logic        lru_update_en;
  logic [3:0]  lru_set_index;
  logic [1:0]  lru_way;
  logic [3:0]  lru_value;

  tlb_storage dut (
    .clk(clk), .rst(rst), .rd_set_index(rd_set_index),
    .rd_valid(rd_valid), .rd_vpn(rd_vpn), .rd_ppn(rd_ppn),
    .rd_perms(rd_perms), .rd_lru_count(rd_lru_count),
    .wr_en(wr_en), .wr_set_index(wr_set_index), .wr_way(wr_way),
    .wr_valid(wr_valid), .wr_vpn(wr_vpn), .wr_ppn(wr_ppn),
    .wr_perms(wr_perms), .wr_lru_count(wr_lru_count),
    .lru_update_en(lru_update_en), .lru_set_index(lru_set_index),
    .lru_way(lru_way), .lru_value(lru_value)
  );

  always #5 clk = ~clk;

  // Reference model: one record per entry; known marks payload that has a defined value.
  bit        m_valid [16][4];
  bit [19:0] m_vpn   [16][4];
  bit [19:0] m_ppn   [16][4];
  bit [1:0]  m_perms [16][4];
  bit [3:0]  m_lru   [16][4];
  bit        m_known [16][4];

  typedef struct {
    bit [3:0]  set;
    bit        valid [4];
    bit [19:0] vpn   [4];
    bit [19:0] ppn   [4];
    bit [1:0]  perms [4];
    bit [3:0]  lru   [4];
    bit        known [4];
  } exp_t;

  exp_t exp_q[$];
  bit   chk_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares whatever the DUT presents for the requested set.
  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow: check requested with empty expected queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int w = 0; w < 4; w++) begin
          checks++;
          if (rd_valid[w] !== e.valid[w] || rd_lru_count[w] !== e.lru[w]) begin
            errors++;
            $display("FAIL ctrl set%0d way%0d: got valid=%b lru=%0d, want valid=%b lru=%0d",
                     e.set, w, rd_valid[w], rd_lru_count[w], e.valid[w], e.lru[w]);
          end
          if (e.known[w]) begin
            checks++;
            if (rd_vpn[w] !== e.vpn[w] || rd_ppn[w] !== e.ppn[w] || rd_perms[w] !== e.perms[w]) begin
              errors++;
              $display("FAIL data set%0d way%0d: got vpn=%h ppn=%h perms=%b, want vpn=%h ppn=%h perms=%b",
                       e.set, w, rd_vpn[w], rd_ppn[w], rd_perms[w], e.vpn[w], e.ppn[w], e.perms[w]);
            end
          end
        end
      end
    end
  end

  // One clock cycle: drive ports, optionally queue the current model view of rs, then commit the model at the edge.
  task automatic cyc(input bit r,
                     input bit we, input bit [3:0] ws, input bit [1:0] ww, input bit wv,
                     input bit [19:0] wvpn, input bit [19:0] wppn, input bit [1:0] wprm, input bit [3:0] wlru,
                     input bit le, input bit [3:0] ls, input bit [1:0] lw, input bit [3:0] lv,
                     input bit chk, input bit [3:0] rs);
    rst = r;
    wr_en = we; wr_set_index = ws; wr_way = ww; wr_valid = wv;
    wr_vpn = wvpn; wr_ppn = wppn; wr_perms = wprm; wr_lru_count = wlru;
    lru_update_en = le; lru_set_index = ls; lru_way = lw; lru_value = lv;
    rd_set_index = rs;
    if (chk) begin
      exp_t e;
      e.set = rs;
      for (int w = 0; w < 4; w++) begin
        e.valid[w] = m_valid[rs][w]; e.vpn[w] = m_vpn[rs][w]; e.ppn[w] = m_ppn[rs][w];
        e.perms[w] = m_perms[rs][w]; e.lru[w] = m_lru[rs][w]; e.known[w] = m_known[rs][w];
      end
      exp_q.push_back(e);
      chk_req = 1'b1;
    end
    @(negedge clk);
    @(posedge clk);
    if (r) begin
      for (int s = 0; s < 16; s++) begin
        for (int w = 0; w < 4; w++) begin
          m_valid[s][w] = 1'b0;
          m_lru[s][w]   = '0;
`ifdef TLB_STORAGE_FULL_RESET_EN
          m_vpn[s][w] = '0; m_ppn[s][w] = '0; m_perms[s][w] = '0; m_known[s][w] = 1'b1;
`endif
        end
      end
    end else begin
      if (le) m_lru[ls][lw] = lv;
      if (we) begin
        m_valid[ws][ww] = wv; m_vpn[ws][ww] = wvpn; m_ppn[ws][ww] = wppn;
        m_perms[ws][ww] = wprm; m_lru[ws][ww] = wlru; m_known[ws][ww] = 1'b1;
      end
    end
    #1;
    chk_req = 1'b0;
  endtask

  task automatic wr(input bit [3:0] s, input bit [1:0] w, input bit [19:0] vpn,
                    input bit [19:0] ppn, input bit [1:0] prm, input bit [3:0] lru);
    cyc(0, 1, s, w, 1, vpn, ppn, prm, lru, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input bit [3:0] s);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, s);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; lru_update_en = 1'b0; rd_set_index = '0;
    wr_set_index = '0; wr_way = '0; wr_valid = 1'b0; wr_vpn = '0; wr_ppn = '0;
    wr_perms = '0; wr_lru_count = '0; lru_set_index = '0; lru_way = '0; lru_value = '0;
    @(posedge clk); #1;

    // Reset for two cycles, with a colliding write to confirm reset priority.
    cyc(1, 1, 4'd2, 2'd0, 1, 20'h11111, 20'h22222, 2'b01, 4'd9, 1, 4'd2, 2'd1, 4'd7, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 16; s++) rd(4'(s));

    // Single write.
    wr(4'd5, 2'd2, 20'hABCDE, 20'h12345, 2'b11, 4'd0);
    rd(4'd5);

    // Fill and overwrite.
    for (int w = 0; w < 4; w++)
      wr(4'd3, 2'(w), 20'h30000 + 20'(w), 20'h40000 + 20'(w * 3), 2'(w), 4'(w + 1));
    rd(4'd3);
    wr(4'd3, 2'd1, 20'hAAAAA, 20'hBBBBB, 2'b11, 4'd2);
    rd(4'd3);

    // LRU-only update.
    wr(4'd7, 2'd0, 20'h77777, 20'h88888, 2'b10, 4'd3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd7, 2'd0, 4'd15, 0, 0);
    rd(4'd7);

    // Same-entry collision, then different-entry simultaneous updates.
    cyc(0, 1, 4'd8, 2'd1, 1, 20'h88881, 20'h99991, 2'b01, 4'd5, 1, 4'd8, 2'd1, 4'd10, 0, 0);
    rd(4'd8);
    cyc(0, 1, 4'd8, 2'd2, 1, 20'h88882, 20'h99992, 2'b10, 4'd6, 1, 4'd3, 2'd0, 4'd12, 0, 0);
    rd(4'd8);
    rd(4'd3);

    // Read of the entry being written shows the old value until the edge.
    cyc(0, 1, 4'd5, 2'd2, 0, 20'h55555, 20'h66666, 2'b00, 4'd1, 0, 0, 0, 0, 1, 4'd5);
    rd(4'd5);

    // Way 0 of every set.
    for (int s = 0; s < 16; s++) wr(4'(s), 2'd0, 20'h10000 + 20'(s), 20'h20000 + 20'(s), 2'(s), 4'(s));
    for (int s = 0; s < 16; s++) rd(4'(s));

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 1'($urandom), 20'($urandom),
          20'($urandom), 2'($urandom), 4'($urandom),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 2'($urandom), 4'($urandom),
          1'b1, 4'($urandom));
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
